// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcode and FSM state definitions for the shared bitwise logic unit arbiter.
package logic_unit_arbiter_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOT     = 3'd0;
  localparam op_t OP_OR      = 3'd1;
  localparam op_t OP_NOR     = 3'd2;
  localparam op_t OP_AND     = 3'd3;
  localparam op_t OP_NAND    = 3'd4;
  localparam op_t OP_XOR     = 3'd5;
  localparam op_t OP_XNOR    = 3'd6;
  localparam op_t OP_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/logic_unit_arbiter_logic_unit.sv
// Stateless gate set: evaluates one bitwise operation on a and b.
module logic_unit
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op)
      OP_NOT:  y = ~a;
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter scheduling NREQ requesters onto one shared logic unit,
// returning each result on a single tagged valid/ready response channel.
module logic_unit_arbiter
  import logic_unit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [OP_W*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]      req_a,
  input  logic [WIDTH*NREQ-1:0]      req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]           rsp_data,
  output logic                       rsp_err,
  output logic                       busy
);

  localparam int unsigned IDW = $clog2(NREQ);

  state_e           state_q;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   id_q;
  op_t              op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             rsp_valid_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic             busy_q;

  logic [IDW:0]     pick_c;
  logic [IDW-1:0]   win_c;
  logic             grant_c;
  logic [WIDTH-1:0] lu_y;
  logic             lu_err;

  // Search starts just after the last winner and wraps; returns {found, index}.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  last);
    logic           found;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] cand;
    int unsigned    c;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      c    = (32'(last) + k) % NREQ;
      cand = IDW'(c);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign pick_c  = rr_pick(req_valid, last_q);
  assign win_c   = pick_c[IDW-1:0];
  // Accept strobe is suppressed while reset is held so no requester sees a phantom grant.
  assign grant_c = (state_q == ST_IDLE) && pick_c[IDW] && rst_n;

  always_comb begin
    req_ready = '0;
    if (grant_c) req_ready[win_c] = 1'b1;
  end

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y   (lu_y),
    .err (lu_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      op_q        <= OP_NOT;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_c) begin
            last_q  <= win_c;
            id_q    <= win_c;
            op_q    <= req_op[OP_W*32'(win_c) +: OP_W];
            a_q     <= req_a[WIDTH*32'(win_c) +: WIDTH];
            b_q     <= req_b[WIDTH*32'(win_c) +: WIDTH];
            busy_q  <= 1'b1;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data_q  <= lu_y;
          rsp_err_q   <= lu_err;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed self-checking bench for logic_unit_arbiter with hand-computed expectations.
module tb_logic_unit_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op = '0;
  logic [WIDTH*NREQ-1:0] req_a = '0;
  logic [WIDTH*NREQ-1:0] req_b = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic                  busy;

  int total = 0;
  int bad   = 0;

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3]         = op;
    req_a[WIDTH*i +: WIDTH]  = a;
    req_b[WIDTH*i +: WIDTH]  = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.req_ready", 32'(req_ready), 32'h0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst.rsp_id",    32'(rsp_id),    32'h0);
    chk("rst.rsp_data",  32'(rsp_data),  32'h0);
    chk("rst.rsp_err",   32'(rsp_err),   32'h0);
    chk("rst.busy",      32'(busy),      32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // One complete transaction: grant now, EXEC next cycle, response two cycles after grant.
  task automatic txn(input string tag, input int id, input logic [7:0] d, input logic e);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    #1;
    chk({tag, ".grant"}, 32'(req_ready), 32'(oh));
    tick();
    chk({tag, ".exec_ready"}, 32'(req_ready), 32'h0);
    chk({tag, ".exec_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, ".exec_busy"},  32'(busy),      32'h1);
    tick();
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h1);
    chk({tag, ".rsp_data"},  32'(rsp_data),  32'(d));
    chk({tag, ".rsp_id"},    32'(rsp_id),    32'(id));
    chk({tag, ".rsp_err"},   32'(rsp_err),   32'(e));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, ".done_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, ".done_busy"},  32'(busy),      32'h0);
  endtask

  initial begin
    #1;
    do_reset();

    // Lone requester 2, AND
    set_req(2, 3'd3, 8'hF0, 8'h3C);
    req_valid = 4'b0100;
    txn("solo2", 2, 8'h30, 1'b0);

    // All requesters contending from reset: strict rotation
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 3'd5, 8'hAA, 8'h0F);
    req_valid = 4'b1111;
    txn("rr0", 0, 8'hA5, 1'b0);
    txn("rr1", 1, 8'hA5, 1'b0);
    txn("rr2", 2, 8'hA5, 1'b0);
    txn("rr3", 3, 8'hA5, 1'b0);
    txn("rr0b", 0, 8'hA5, 1'b0);

    // Opcode sweep on requester 0
    req_valid = 4'b0001;
    set_req(0, 3'd0, 8'hC5, 8'h5A); txn("not",  0, 8'h3A, 1'b0);
    set_req(0, 3'd1, 8'hC5, 8'h5A); txn("or",   0, 8'hDF, 1'b0);
    set_req(0, 3'd2, 8'hC5, 8'h5A); txn("nor",  0, 8'h20, 1'b0);
    set_req(0, 3'd3, 8'hC5, 8'h5A); txn("and",  0, 8'h40, 1'b0);
    set_req(0, 3'd4, 8'hC5, 8'h5A); txn("nand", 0, 8'hBF, 1'b0);
    set_req(0, 3'd5, 8'hC5, 8'h5A); txn("xor",  0, 8'h9F, 1'b0);
    set_req(0, 3'd6, 8'hC5, 8'h5A); txn("xnor", 0, 8'h60, 1'b0);
    set_req(0, 3'd7, 8'hC5, 8'h5A); txn("ill",  0, 8'h00, 1'b1);

    // Backpressure: last grant was 0, so requester 1 wins and RESP is held
    for (int i = 0; i < 4; i++) set_req(i, 3'd1, 8'h12, 8'h34);
    req_valid = 4'b1111;
    #1;
    chk("bp.grant", 32'(req_ready), 32'h2);
    tick();
    tick();
    for (int n = 0; n < 5; n++) begin
      chk("bp.rsp_valid", 32'(rsp_valid), 32'h1);
      chk("bp.rsp_data",  32'(rsp_data),  32'h36);
      chk("bp.rsp_id",    32'(rsp_id),    32'h1);
      chk("bp.req_ready", 32'(req_ready), 32'h0);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    tick();
    rsp_ready = 1'b0;
    chk("bp.done_valid", 32'(rsp_valid), 32'h0);

    // Reset while in EXEC discards the operation
    set_req(2, 3'd3, 8'hF0, 8'h3C);
    req_valid = 4'b0100;
    #1;
    chk("rx.grant", 32'(req_ready), 32'h4);
    tick();
    chk("rx.in_exec", 32'(busy), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rx.rst_ready", 32'(req_ready), 32'h0);
    chk("rx.rst_valid", 32'(rsp_valid), 32'h0);
    chk("rx.rst_busy",  32'(busy),      32'h0);
    req_valid = '0;
    tick();
    tick();
    chk("rx.hold_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rx.post_valid", 32'(rsp_valid), 32'h0);
    chk("rx.post_busy",  32'(busy),      32'h0);
    set_req(0, 3'd3, 8'hF0, 8'h3C);
    set_req(3, 3'd5, 8'hAA, 8'h0F);
    req_valid = 4'b1001;
    txn("rx.first0", 0, 8'h30, 1'b0);

    // Wrap after granting 3: 1 then 3
    req_valid = 4'b1000;
    txn("wrap.g3", 3, 8'hA5, 1'b0);
    set_req(1, 3'd5, 8'hAA, 8'h0F);
    req_valid = 4'b1010;
    txn("wrap.g1", 1, 8'hA5, 1'b0);
    txn("wrap.g3b", 3, 8'hA5, 1'b0);
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
